// File: rtl/alu_cskpa.sv
// alu_cskpa -- registered 32-bit ALU built around a carry-skip adder.
//
// Purpose:
//   Decodes a 4-bit opcode and registers the selected result one clock after
//   the operands and opcode are sampled. A new operation can be issued every
//   cycle. ADD, SUB, INC and DEC share one carry-skip adder. MUL uses a
//   recursive Vedic (Urdhva-Tiryakbhyam) multiplier.
//
// Build option:
//   ALU_CSKPA_MUL_EN -- when defined, the Vedic multiplier is built and
//                       opcode 2 returns A*B. When undefined, no multiplier
//                       logic exists and opcode 2 returns all zeros.
//
// Parameters:
//   WIDTH  operand/result width (only 32 is supported)
//   BLOCK  carry-skip block size in bits (WIDTH must be a multiple of BLOCK)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; clears every output
//   operand1   in   operand A
//   operand2   in   operand B (bits [4:0] are the shift amount)
//   opcode     in   operation select
//   result     out  registered ALU result
//   carry_out  out  registered carry / no-borrow flag
//   product    out  registered 64-bit product (zero unless opcode is MUL)

`ifdef ALU_CSKPA_MUL_EN
// Recursive Vedic multiplier. Each level splits the operands into halves,
// forms the four half-width partial products, and then merges the vertical
// (ll, hh) and crosswise (hl + lh) terms.
module alu_cskpa_vedic #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    if (N == 2) begin : g_base
        logic [1:0] cross;
        logic [1:0] upper;

        assign cross = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
        assign upper = {1'b0, a[1] & b[1]} + {1'b0, cross[1]};
        assign p     = {upper, cross[0], a[0] & b[0]};
    end else begin : g_rec
        localparam int unsigned H = N / 2;

        logic [N-1:0] q_ll;
        logic [N-1:0] q_hl;
        logic [N-1:0] q_lh;
        logic [N-1:0] q_hh;
        logic [N:0]   cross;

        alu_cskpa_vedic #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(q_ll));
        alu_cskpa_vedic #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(q_hl));
        alu_cskpa_vedic #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(q_lh));
        alu_cskpa_vedic #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(q_hh));

        assign cross = {1'b0, q_hl} + {1'b0, q_lh};
        assign p     = {q_hh, q_ll} + ({{(N-1){1'b0}}, cross} << H);
    end
endmodule
`endif

module alu_cskpa #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic [3:0]         opcode,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned NBLK = WIDTH / BLOCK;
    localparam int unsigned SHW  = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_NAND = 4'd7,
        OP_NOR  = 4'd8,
        OP_XNOR = 4'd9,
        OP_SLL  = 4'd10,
        OP_SRL  = 4'd11,
        OP_SRA  = 4'd12,
        OP_SLT  = 4'd13,
        OP_INC  = 4'd14,
        OP_DEC  = 4'd15
    } op_e;

    // Carry-skip adder: ripple within each BLOCK-bit group. When every
    // propagate bit in a group is set, the group's carry-in is forwarded
    // directly as its carry-out. The operands are consumed LSB-first by
    // shifting, so no variable bit-select is needed.
    function automatic logic [WIDTH:0] cskip_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        logic [WIDTH-1:0] a_sh;
        logic [WIDTH-1:0] b_sh;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             rc;
        logic             prop;
        logic             p;
        a_sh = a;
        b_sh = b;
        s    = '0;
        c    = cin;
        rc   = 1'b0;
        prop = 1'b0;
        p    = 1'b0;
        for (int unsigned blk = 0; blk < NBLK; blk++) begin
            rc   = c;
            prop = 1'b1;
            for (int unsigned i = 0; i < BLOCK; i++) begin
                p    = a_sh[0] ^ b_sh[0];
                s    = {p ^ rc, s[WIDTH-1:1]};
                rc   = (a_sh[0] & b_sh[0]) | (p & rc);
                prop = prop & p;
                a_sh = a_sh >> 1;
                b_sh = b_sh >> 1;
            end
            c = prop ? c : rc;
        end
        return {c, s};
    endfunction

    op_e              op;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0]   nxt_result;
    logic               nxt_carry;
    logic [2*WIDTH-1:0] nxt_product;

    assign op    = op_e'(opcode);
    assign shamt = operand2[SHW-1:0];

`ifdef ALU_CSKPA_MUL_EN
    logic [2*WIDTH-1:0] mul_full;

    alu_cskpa_vedic #(.N(WIDTH)) u_mul (
        .a(operand1),
        .b(operand2),
        .p(mul_full)
    );
`endif

    // Operand conditioning for the shared adder:
    // SUB = A + ~B + 1, INC = A + 0 + 1, DEC = A + all-ones + 0.
    // For DEC, the carry-out is set unless A is zero.
    always_comb begin
        add_b   = operand2;
        add_cin = 1'b0;
        case (op)
            OP_SUB: begin
                add_b   = ~operand2;
                add_cin = 1'b1;
            end
            OP_INC: begin
                add_b   = '0;
                add_cin = 1'b1;
            end
            OP_DEC: begin
                add_b   = '1;
                add_cin = 1'b0;
            end
            default: ;
        endcase
        sum = cskip_add(operand1, add_b, add_cin);
    end

    always_comb begin
        nxt_result  = '0;
        nxt_carry   = 1'b0;
        nxt_product = '0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                nxt_result = sum[WIDTH-1:0];
                nxt_carry  = sum[WIDTH];
            end
            OP_MUL: begin
`ifdef ALU_CSKPA_MUL_EN
                nxt_product = mul_full;
                nxt_result  = mul_full[WIDTH-1:0];
`endif
            end
            OP_AND:  nxt_result = operand1 & operand2;
            OP_OR:   nxt_result = operand1 | operand2;
            OP_XOR:  nxt_result = operand1 ^ operand2;
            OP_NOT:  nxt_result = ~operand1;
            OP_NAND: nxt_result = ~(operand1 & operand2);
            OP_NOR:  nxt_result = ~(operand1 | operand2);
            OP_XNOR: nxt_result = ~(operand1 ^ operand2);
            OP_SLL:  nxt_result = operand1 << shamt;
            OP_SRL:  nxt_result = operand1 >> shamt;
            OP_SRA:  nxt_result = $unsigned($signed(operand1) >>> shamt);
            OP_SLT:  nxt_result = {{(WIDTH-1){1'b0}},
                                   $signed(operand1) < $signed(operand2)};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
            product   <= '0;
        end else begin
            result    <= nxt_result;
            carry_out <= nxt_carry;
            product   <= nxt_product;
        end
    end
endmodule

// File: tb/tb_alu_cskpa.sv
// Directed, table-driven bench for alu_cskpa. Expected MUL values follow
// whether ALU_CSKPA_MUL_EN is defined for the build.
module tb_alu_cskpa;
    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  opcode;
    logic [31:0] result;
    logic        carry_out;
    logic [63:0] product;

`ifdef ALU_CSKPA_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    alu_cskpa #(.WIDTH(32), .BLOCK(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .operand1(operand1),
        .operand2(operand2),
        .opcode(opcode),
        .result(result),
        .carry_out(carry_out),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        co;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] res,
                           input logic co, input logic [63:0] prod);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.op = op;
        v.res = res; v.co = co; v.prod = prod;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [31:0] res, input logic co,
                           input logic [63:0] prod);
        chk({n, ".result"},  {32'h0, result},    {32'h0, res});
        chk({n, ".carry"},   {63'h0, carry_out}, {63'h0, co});
        chk({n, ".product"}, product,            prod);
    endtask

    initial begin
        // name, A, B, opcode, result, carry_out, product
        add_vec("add8",     32'd8, 32'd8, 4'd0, 32'd16, 1'b0, 64'd0);
        add_vec("sub8",     32'd8, 32'd8, 4'd1, 32'd0,  1'b1, 64'd0);
        add_vec("mul8",     32'd8, 32'd8, 4'd2, MUL_ON ? 32'd64 : 32'd0, 1'b0,
                MUL_ON ? 64'd64 : 64'd0);
        add_vec("mulmax",   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2,
                MUL_ON ? 32'h00000001 : 32'd0, 1'b0,
                MUL_ON ? 64'hFFFFFFFE_00000001 : 64'd0);
        add_vec("mulmix",   32'h0000FFFF, 32'h00010001, 4'd2,
                MUL_ON ? 32'hFFFFFFFF : 32'd0, 1'b0,
                MUL_ON ? 64'h00000000_FFFFFFFF : 64'd0);
        add_vec("mulovf",   32'h80000000, 32'd2, 4'd2, 32'd0, 1'b0,
                MUL_ON ? 64'h00000001_00000000 : 64'd0);
        add_vec("and8",     32'd8, 32'd8, 4'd3,  32'd8,        1'b0, 64'd0);
        add_vec("or8",      32'd8, 32'd8, 4'd4,  32'd8,        1'b0, 64'd0);
        add_vec("xor8",     32'd8, 32'd8, 4'd5,  32'd0,        1'b0, 64'd0);
        add_vec("not8",     32'd8, 32'd8, 4'd6,  32'hFFFFFFF7, 1'b0, 64'd0);
        add_vec("nand8",    32'd8, 32'd8, 4'd7,  32'hFFFFFFF7, 1'b0, 64'd0);
        add_vec("nor8",     32'd8, 32'd8, 4'd8,  32'hFFFFFFF7, 1'b0, 64'd0);
        add_vec("xnor8",    32'd8, 32'd8, 4'd9,  32'hFFFFFFFF, 1'b0, 64'd0);
        add_vec("sll8",     32'd8, 32'd8, 4'd10, 32'h00000800, 1'b0, 64'd0);
        add_vec("srl8",     32'd8, 32'd8, 4'd11, 32'd0,        1'b0, 64'd0);
        add_vec("sra8",     32'd8, 32'd8, 4'd12, 32'd0,        1'b0, 64'd0);
        add_vec("slt8",     32'd8, 32'd8, 4'd13, 32'd0,        1'b0, 64'd0);
        add_vec("inc8",     32'd8, 32'd8, 4'd14, 32'd9,        1'b0, 64'd0);
        add_vec("dec8",     32'd8, 32'd8, 4'd15, 32'd7,        1'b1, 64'd0);
        add_vec("sll0",     32'd8, 32'd0, 4'd10, 32'd8,        1'b0, 64'd0);
        add_vec("srl0",     32'd8, 32'd0, 4'd11, 32'd8,        1'b0, 64'd0);
        add_vec("sra0",     32'd8, 32'd0, 4'd12, 32'd8,        1'b0, 64'd0);
        add_vec("sll32",    32'd8, 32'd32, 4'd10, 32'd8,       1'b0, 64'd0);
        add_vec("addwrap",  32'hFFFFFFFF, 32'd1, 4'd0, 32'd0,  1'b1, 64'd0);
        add_vec("dec0",     32'd0, 32'd0, 4'd15, 32'hFFFFFFFF, 1'b0, 64'd0);
        add_vec("incwrap",  32'hFFFFFFFF, 32'd0, 4'd14, 32'd0, 1'b1, 64'd0);
        add_vec("sra4",     32'h80000000, 32'd4, 4'd12, 32'hF8000000, 1'b0, 64'd0);
        add_vec("srl4",     32'h80000000, 32'd4, 4'd11, 32'h08000000, 1'b0, 64'd0);
        add_vec("sltneg",   32'hFFFFFFFF, 32'd1, 4'd13, 32'd1, 1'b0, 64'd0);
        add_vec("sltpos",   32'd1, 32'hFFFFFFFF, 4'd13, 32'd0, 1'b0, 64'd0);
        add_vec("subborrow",32'd3, 32'd5, 4'd1, 32'hFFFFFFFE, 1'b0, 64'd0);
        add_vec("subsgn",   32'h80000000, 32'd1, 4'd1, 32'h7FFFFFFF, 1'b1, 64'd0);
        add_vec("addskip",  32'h0000FFFF, 32'd1, 4'd0, 32'h00010000, 1'b0, 64'd0);
        add_vec("addmix",   32'h12345678, 32'h9ABCDEF0, 4'd0, 32'hACF13568, 1'b0, 64'd0);
        add_vec("xorpat",   32'hA5A5A5A5, 32'h0F0F0F0F, 4'd5, 32'hAAAAAAAA, 1'b0, 64'd0);

        // Reset state
        rst_n = 1'b0; operand1 = 32'd8; operand2 = 32'd8; opcode = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        chk_all("reset", 32'd0, 1'b0, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Table: drive at negedge, sample 1 time unit after the capturing edge
        foreach (vecs[i]) begin
            @(negedge clk);
            operand1 = vecs[i].a; operand2 = vecs[i].b; opcode = vecs[i].op;
            @(posedge clk); #1;
            chk_all(vecs[i].name, vecs[i].res, vecs[i].co, vecs[i].prod);
        end

        // Back-to-back issue: each negedge checks the previous op and drives the next
        @(negedge clk); operand1 = 32'd1;  operand2 = 32'd2; opcode = 4'd0;
        @(negedge clk); chk_all("b2b.add", 32'd3, 1'b0, 64'd0);
        operand1 = 32'd10; operand2 = 32'd3; opcode = 4'd1;
        @(negedge clk); chk_all("b2b.sub", 32'd7, 1'b1, 64'd0);
        operand1 = 32'h1;  operand2 = 32'd31; opcode = 4'd10;
        @(negedge clk); chk_all("b2b.sll", 32'h80000000, 1'b0, 64'd0);
        operand1 = 32'd6;  operand2 = 32'd7;  opcode = 4'd2;
        @(negedge clk); chk_all("b2b.mul", MUL_ON ? 32'd42 : 32'd0, 1'b0,
                                MUL_ON ? 64'd42 : 64'd0);

        // Asynchronous reset pulse between clock edges
        operand1 = 32'hFFFFFFFF; operand2 = 32'd1; opcode = 4'd0;
        @(posedge clk); #2;
        chk_all("pre_rst", 32'd0, 1'b1, 64'd0);
        operand1 = 32'd8; operand2 = 32'd8;
        @(posedge clk); #2;
        chk_all("pre_rst2", 32'd16, 1'b0, 64'd0);
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", 32'd0, 1'b0, 64'd0);
        @(posedge clk); #1;
        chk_all("rst_hold", 32'd0, 1'b0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; operand1 = 32'd9; operand2 = 32'd4; opcode = 4'd1;
        #1;
        chk_all("rst_release", 32'd0, 1'b0, 64'd0);
        @(posedge clk); #1;
        chk_all("rst_first_op", 32'd5, 1'b1, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
